// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS symbol aligner and 10b->8b/control decoder for one channel
module tmds_decoder #(
   parameter int TOKEN_LOCK   = 16,
   parameter int SEARCH_WORDS = 2048,
   parameter int LOSS_WORDS   = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] raw_word,
   output logic [7:0] vd,
   output logic [1:0] cd,
   output logic       vde,
   output logic       locked,
   output logic [3:0] offset
);
   localparam int CW = $clog2((SEARCH_WORDS > LOSS_WORDS ? SEARCH_WORDS : LOSS_WORDS) + 1);
   localparam int RW = $clog2(TOKEN_LOCK + 1);
   typedef enum logic {SEARCH, LOCKED} state_t;
   state_t state, state_nxt;
   logic [9:0] raw_q, sym;
   logic [19:0] win;
   logic [CW-1:0] word_cnt;
   logic [RW-1:0] run_cnt, run_nxt;
   logic tok, run_hit, search_end, loss, advance, vde_nxt;
   logic [1:0] tok_cd, cd_nxt;
   logic [7:0] q, dec, vd_nxt;
   assign win = {raw_word, raw_q};
   assign locked = state == LOCKED;
   // classify the aligned symbol and decode it as data in parallel
   always_comb begin
      tok = sym == 10'h354 || sym == 10'h0AB || sym == 10'h154 || sym == 10'h2AB;
      tok_cd = sym == 10'h354 ? 2'd0 : sym == 10'h0AB ? 2'd1 : sym == 10'h154 ? 2'd2 : 2'd3;
      q = sym[7:0] ^ {8{sym[9]}};
      dec = q ^ {q[6:0], 1'b0} ^ {{7{~sym[8]}}, 1'b0};
      run_nxt = !tok ? '0 : run_cnt == RW'(TOKEN_LOCK) ? run_cnt : run_cnt + 1'b1;
      run_hit = run_nxt == RW'(TOKEN_LOCK);
      search_end = word_cnt == CW'(SEARCH_WORDS - 1);
      loss = word_cnt == CW'(LOSS_WORDS - 1);
   end
   // next state: a full token run locks (and beats a pending offset advance); a silent window unlocks
   always_comb begin
      state_nxt = state == SEARCH ? (run_hit ? LOCKED : SEARCH) : (!run_hit && loss ? SEARCH : LOCKED);
      advance = !run_hit && (state == SEARCH ? search_end : loss);
   end
   // outputs are qualified by the state being entered, so the locking token itself is reported
   always_comb begin
      vde_nxt = state_nxt == LOCKED && !tok;
      vd_nxt = vde_nxt ? dec : 8'd0;
      cd_nxt = state_nxt == LOCKED && tok ? tok_cd : cd;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= SEARCH;
      else state <= state_nxt;
   end
   // alignment window, offset hunting counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q <= '0;
         sym <= '0;
         offset <= '0;
         run_cnt <= '0;
         word_cnt <= '0;
         vd <= '0;
         cd <= '0;
         vde <= 1'b0;
      end else begin
         raw_q <= raw_word;
         sym <= win[offset +: 10];
         offset <= advance ? (offset == 4'd9 ? 4'd0 : offset + 4'd1) : offset;
         run_cnt <= advance ? '0 : run_nxt;
         word_cnt <= advance || run_hit ? '0 : word_cnt + 1'b1;
         vd <= vd_nxt;
         cd <= cd_nxt;
         vde <= vde_nxt;
      end
   end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed checks of alignment, lock/loss and symbol decode
module tb_tmds_decoder;
   logic clk = 0, rst = 1;
   logic [9:0] raw_word = '0;
   logic [7:0] vd;
   logic [1:0] cd;
   logic vde, locked;
   logic [3:0] offset;
   int checks = 0, errors = 0;
   logic [9:0] line [800];
   logic [9:0] syms [16];
   logic [7:0] vals [16];

   tmds_decoder dut (.clk(clk), .rst(rst), .raw_word(raw_word), .vd(vd), .cd(cd),
                     .vde(vde), .locked(locked), .offset(offset));

   always #5 clk = ~clk;

   task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task send(input logic [9:0] w);
      raw_word = w;
      @(negedge clk);
   endtask

   task do_reset();
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   function automatic logic [9:0] enc(input logic [7:0] v, input logic xm, input logic inv);
      logic [7:0] qm;
      qm[0] = v[0];
      for (int i = 1; i < 8; i++) qm[i] = xm ? qm[i-1] ^ v[i] : ~(qm[i-1] ^ v[i]);
      return {inv, xm, inv ? ~qm : qm};
   endfunction

   function automatic logic is_tok(input logic [9:0] s);
      return s == 10'h354 || s == 10'h0AB || s == 10'h154 || s == 10'h2AB;
   endfunction

   function automatic logic [9:0] skewed(input int k);
      logic [19:0] pair;
      pair = {line[(k + 1) % 800], line[k % 800]};
      return pair[12:3];
   endfunction

   initial begin
      int k;
      raw_word = '0;
      do_reset();
      check("reset_locked", locked, 0);
      check("reset_offset", offset, 0);
      check("reset_vde", vde, 0);
      // aligned tokens at offset 0: lock after the 16th token reaches the outputs
      for (int i = 0; i < 17; i++) send(10'h354);
      check("prelock", locked, 0);
      send(10'h354);
      check("lock_16th", locked, 1);
      check("lock_cd", cd, 0);
      check("lock_vde", vde, 0);
      for (int i = 18; i < 160; i++) send(10'h354);
      repeat (3) send(10'h100);
      check("d100_vde", vde, 1);
      check("d100_vd", vd, 8'h00);
      check("d100_offset", offset, 0);
      check("d100_locked", locked, 1);
      send(10'h200);
      send(10'h2AB);
      send(10'h2AB);
      check("d200_vd", vd, 8'hFF);
      check("d200_vde", vde, 1);
      send(10'h2AB);
      check("tok11_vde", vde, 0);
      check("tok11_cd", cd, 3);
      check("tok11_vd", vd, 0);
      // encoder-model data sweep in both modes, with and without inversion
      vals = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3,
               8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      for (int i = 0; i < 16; i++) begin
         logic [3:0] iv;
         iv = 4'(i);
         syms[i] = enc(vals[i], iv[0], iv[1]);
         if (is_tok(syms[i])) syms[i] = enc(vals[i], iv[0], ~iv[1]);
      end
      for (int i = 0; i < 18; i++) begin
         send(syms[i < 16 ? i : 15]);
         if (i >= 2) begin
            check("sweep_vd", vd, vals[i-2]);
            check("sweep_vde", vde, 1);
         end
      end
      send(10'h0AB);
      send(10'h200);
      send(10'h200);
      check("tok01_cd", cd, 1);
      check("tok01_vde", vde, 0);
      send(10'h200);
      check("hold01_cd", cd, 1);
      check("hold01_vd", vd, 8'hFF);
      send(10'h154);
      send(10'h200);
      send(10'h200);
      check("tok10_cd", cd, 2);
      send(10'h200);
      check("hold10_cd", cd, 2);
      check("hold10_vde", vde, 1);
      // 7-bit skewed stream of 800-word lines: hunt must settle at offset 7
      for (int i = 0; i < 800; i++) begin
         logic [9:0] s;
         s = enc(8'($urandom), 1'b1, 1'b0);
         if (is_tok(s)) s = enc(s[7:0], 1'b1, 1'b1);
         line[i] = i < 160 ? 10'h354 : s;
      end
      do_reset();
      k = 0;
      while (!locked && k < 20000) begin
         send(skewed(k));
         k++;
      end
      check("skew_locked", locked, 1);
      check("skew_offset", offset, 7);
      repeat (50) begin
         send(skewed(k));
         k++;
      end
      check("skew_hold_offset", offset, 7);
      // loss of lock after LOSS_WORDS data symbols without a token run
      do_reset();
      repeat (20) send(10'h354);
      repeat (4097) send(10'h100);
      check("loss_before", locked, 1);
      send(10'h100);
      check("loss_locked", locked, 0);
      check("loss_offset", offset, 1);
      check("loss_vde", vde, 0);
      // synchronous reset while locked
      do_reset();
      repeat (20) send(10'h2AB);
      repeat (3) send(10'h200);
      check("pre_rst_vd", vd, 8'hFF);
      check("pre_rst_cd", cd, 3);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("rst_locked", locked, 0);
      check("rst_offset", offset, 0);
      check("rst_vde", vde, 0);
      check("rst_vd", vd, 0);
      check("rst_cd", cd, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
